// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register-file geometry and write-back requester indices
package regfile_wb_arbiter_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_ZERO_REG = 0;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LOAD = 2'd1,
    WB_MULDIV = 2'd2
  } wbReqE;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester after last
module rr_arbiter #(
  parameter int N = 3,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);
  int bestDist;
  int bestIdx;
  always_comb begin
    bestDist = N;
    bestIdx = 0;
    grant = '0;
    for (int i = 0; i < N; i++)
      if (req[i] && ((i + 2 * N - int'(last) - 1) % N) < bestDist) begin
        bestDist = (i + 2 * N - int'(last) - 1) % N;
        bestIdx = i;
      end
    for (int i = 0; i < N; i++)
      grant[i] = (bestDist < N) && (bestIdx == i);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         reqValid,
  input  logic [N_REQ*ADDR_W-1:0]  reqNum,
  input  logic [N_REQ*DATA_W-1:0]  reqData,
  output logic [N_REQ-1:0]         reqReady,
  input  logic                     wbStall,
  output logic                     regsWriteEnable,
  output logic [ADDR_W-1:0]        regWriteNum,
  output logic [DATA_W-1:0]        regWriteData,
  input  logic [ADDR_W-1:0]        queryNum,
  output logic                     queryPending,
  output logic [31:0]              writeCount
);
  localparam int LW = $clog2(N_REQ);
  logic [LW-1:0] last;
  logic [LW-1:0] grantIdx;
  logic [N_REQ-1:0] grant;
  logic handshake;
  logic [ADDR_W-1:0] selNum;
  logic [DATA_W-1:0] selData;
  logic enReg;
  logic pend;
  rr_arbiter #(.N(N_REQ), .LW(LW)) uArb (.req(reqValid), .last(last), .grant(grant));
  assign reqReady = (wbStall || rst) ? '0 : grant;
  assign handshake = |(reqValid & reqReady);
  // a write held in the output stage is dropped as soon as reset is seen
  assign regsWriteEnable = enReg && !rst;
  always_comb begin
    grantIdx = '0;
    selNum = '0;
    selData = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) begin
        grantIdx = LW'(i);
        selNum = reqNum[i*ADDR_W +: ADDR_W];
        selData = reqData[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    pend = regsWriteEnable && (regWriteNum == queryNum);
    for (int i = 0; i < N_REQ; i++)
      pend = pend || (reqValid[i] && (reqNum[i*ADDR_W +: ADDR_W] == queryNum));
    queryPending = (queryNum != ADDR_W'(RF_ZERO_REG)) && pend;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= LW'(N_REQ - 1);
      enReg <= 1'b0;
      regWriteNum <= '0;
      regWriteData <= '0;
      writeCount <= '0;
    end else begin
      enReg <= handshake && (selNum != ADDR_W'(RF_ZERO_REG));
      if (handshake) last <= grantIdx;
      if (handshake && (selNum != ADDR_W'(RF_ZERO_REG))) begin
        regWriteNum <= selNum;
        regWriteData <= selData;
        writeCount <= writeCount + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors checked against a behavioural write-back model
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] reqValid;
  logic [N*5-1:0] reqNum;
  logic [N*32-1:0] reqData;
  logic [N-1:0] reqReady;
  logic wbStall;
  logic regsWriteEnable;
  logic [4:0] regWriteNum;
  logic [31:0] regWriteData;
  logic [4:0] queryNum;
  logic queryPending;
  logic [31:0] writeCount;
  int checks = 0;
  int errors = 0;
  logic run = 1'b0;

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqNum(reqNum), .reqData(reqData),
    .reqReady(reqReady), .wbStall(wbStall), .regsWriteEnable(regsWriteEnable),
    .regWriteNum(regWriteNum), .regWriteData(regWriteData), .queryNum(queryNum),
    .queryPending(queryPending), .writeCount(writeCount)
  );

  always #5 clk = ~clk;

  // model: last granted requester, the write now on the port, and the commit count
  int mLast = N - 1;
  logic mEn = 1'b0;
  logic [4:0] mNum = '0;
  logic [31:0] mData = '0;
  logic [31:0] mCount = '0;

  function automatic int modelGrant();
    if (rst || wbStall) return -1;
    for (int k = 1; k <= N; k++)
      if (reqValid[(mLast + k) % N]) return (mLast + k) % N;
    return -1;
  endfunction

  function automatic logic modelQuery();
    if (queryNum == 5'd0) return 1'b0;
    if (mEn && !rst && mNum == queryNum) return 1'b1;
    for (int i = 0; i < N; i++)
      if (reqValid[i] && reqNum[i*5 +: 5] == queryNum) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mLast <= N - 1;
      mEn <= 1'b0;
      mNum <= '0;
      mData <= '0;
      mCount <= '0;
    end else begin
      mEn <= 1'b0;
      if (modelGrant() >= 0) begin
        mLast <= modelGrant();
        if (reqNum[modelGrant()*5 +: 5] != 5'd0) begin
          mEn <= 1'b1;
          mNum <= reqNum[modelGrant()*5 +: 5];
          mData <= reqData[modelGrant()*32 +: 32];
          mCount <= mCount + 32'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m_reqReady", 32'(reqReady), (modelGrant() < 0) ? 32'd0 : (32'd1 << modelGrant()));
      chk("m_enable", 32'(regsWriteEnable), 32'(mEn && !rst));
      if (mEn && !rst) begin
        chk("m_num", 32'(regWriteNum), 32'(mNum));
        chk("m_data", regWriteData, mData);
      end
      chk("m_count", writeCount, mCount);
      chk("m_query", 32'(queryPending), 32'(modelQuery()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [4:0] num, input logic [31:0] data);
    reqNum[i*5 +: 5] = num;
    reqData[i*32 +: 32] = data;
  endtask

  initial begin
    rst = 1'b1;
    reqValid = '0;
    reqNum = '0;
    reqData = '0;
    wbStall = 1'b0;
    queryNum = '0;
    @(posedge clk);
    run = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(reqReady), 32'd0);
    chk("rst_en", 32'(regsWriteEnable), 32'd0);
    chk("rst_count", writeCount, 32'd0);
    tick();
    rst = 1'b0;
    reqValid = 3'b001;
    setReq(WB_ALU, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 32'(reqReady), 32'd1);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("single_en", 32'(regsWriteEnable), 32'd1);
    chk("single_num", 32'(regWriteNum), 32'd5);
    chk("single_data", regWriteData, 32'hDEADBEEF);
    chk("single_count", writeCount, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setReq(WB_ALU, 5'd1, 32'hA);
    setReq(WB_LOAD, 5'd2, 32'hB);
    setReq(WB_MULDIV, 5'd3, 32'hC);
    reqValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_ready", 32'(reqReady), 32'd1 << (c % 3));
      tick();
    end
    reqValid = '0;
    @(negedge clk);
    chk("rr_count", writeCount, 32'd6);
    chk("rr_num", 32'(regWriteNum), 32'd3);
    tick();
    reqValid = 3'b010;
    setReq(WB_LOAD, 5'd0, 32'h1234);
    queryNum = 5'd0;
    @(negedge clk);
    chk("x0_ready", 32'(reqReady), 32'd2);
    chk("x0_query", 32'(queryPending), 32'd0);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("x0_en", 32'(regsWriteEnable), 32'd0);
    chk("x0_count", writeCount, 32'd6);
    tick();
    reqValid = 3'b010;
    setReq(WB_LOAD, 5'd4, 32'h55);
    wbStall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_ready", 32'(reqReady), 32'd0);
      chk("stall_en", 32'(regsWriteEnable), 32'd0);
      tick();
    end
    wbStall = 1'b0;
    @(negedge clk);
    chk("unstall_ready", 32'(reqReady), 32'd2);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("unstall_num", 32'(regWriteNum), 32'd4);
    tick();
    reqValid = 3'b100;
    setReq(WB_MULDIV, 5'd7, 32'h77);
    queryNum = 5'd7;
    @(negedge clk);
    chk("q_req", 32'(queryPending), 32'd1);
    chk("q_ready", 32'(reqReady), 32'd4);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("q_out", 32'(queryPending), 32'd1);
    tick();
    @(negedge clk);
    chk("q_clear", 32'(queryPending), 32'd0);
    tick();
    reqValid = 3'b001;
    setReq(WB_ALU, 5'd9, 32'h99);
    @(negedge clk);
    chk("mid_ready", 32'(reqReady), 32'd1);
    tick();
    reqValid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_en1", 32'(regsWriteEnable), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_en2", 32'(regsWriteEnable), 32'd0);
    chk("mid_count", writeCount, 32'd0);
    tick();
    reqValid = 3'b111;
    @(negedge clk);
    chk("mid_next", 32'(reqReady), 32'd1);
    tick();
    reqValid = '0;
    tick();
    tick();
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
